// File: rtl/axi_rd_mst_ctrl_pkg.sv
// Shared definitions for the AXI4 read master controller: width defaults,
// AXI response/burst/size codes, the AR slice state type and a helper.
package axi_rd_mst_ctrl_pkg;

  // Default widths used by the controller and its interface
  localparam int AXI_ID_W_DEF   = 4;
  localparam int AXI_ADDR_W_DEF = 32;
  localparam int AXI_DATA_W_DEF = 32;
  localparam int AXI_LEN_W_DEF  = 8;

  // RRESP codes; numeric order doubles as severity order
  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  // ARBURST codes (2'b11 is reserved by AXI)
  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  // ARSIZE codes (bytes per beat = 2**size)
  localparam logic [2:0] AXI_SIZE_1B   = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B   = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B   = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B   = 3'd3;
  localparam logic [2:0] AXI_SIZE_16B  = 3'd4;
  localparam logic [2:0] AXI_SIZE_32B  = 3'd5;
  localparam logic [2:0] AXI_SIZE_64B  = 3'd6;
  localparam logic [2:0] AXI_SIZE_128B = 3'd7;

  // AR register slice: empty, or holding one request until arready
  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  // Worst-of two responses; the encoding is already ordered by severity
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_rd_mst_ctrl_if.sv
// AXI4 read-address and read-data channel bundle with master/slave views.
interface axi_rd_mst_ctrl_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);

  // AR channel
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  // R channel
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_rd_tag_fifo.sv
// Synchronous tag FIFO holding {id,len} of every burst issued on AR and
// not yet terminated by rlast. Push and pop in the same cycle are legal
// even when full: the head is read before the freed slot is rewritten.
module axi_rd_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // Pointer update; reset empties the FIFO
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write
  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/axi_rd_mst_ctrl.sv
// Command-driven AXI4 read master. Commands are registered into an AR slice
// and issued with an auto-incrementing ID; issued bursts are tracked in a tag
// FIFO. R beats are forwarded one cycle later, checked against the FIFO head,
// and each burst closes with a one-cycle completion record.
module axi_rd_mst_ctrl
  import axi_rd_mst_ctrl_pkg::*;
#(
  parameter int ID_W     = AXI_ID_W_DEF,
  parameter int ADDR_W   = AXI_ADDR_W_DEF,
  parameter int DATA_W   = AXI_DATA_W_DEF,
  parameter int LEN_W    = AXI_LEN_W_DEF,
  parameter int MAX_OUTS = 4,
  parameter int ERRCNT_W = 16,
  localparam int CNT_W   = $clog2(MAX_OUTS) + 1
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic                rready_en,

  axi_rd_mst_ctrl_if.master   axi_mst,

  output logic                beat_valid,
  output logic [DATA_W-1:0]   beat_data,
  output logic [LEN_W-1:0]    beat_idx,

  output logic                done_valid,
  output logic [ID_W-1:0]     done_id,
  output logic [1:0]          done_resp,
  output logic [LEN_W:0]      done_beats,
  output logic                done_err,

  output logic [CNT_W-1:0]    outs_cnt,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int TAG_W = ID_W + LEN_W;

  // AR slice
  ar_state_e         state_q, state_d;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;
  logic [ID_W-1:0]   id_cnt_q;
  logic              cmd_hs;
  logic              ar_hs;

  // Burst tracking
  logic [CNT_W-1:0]  outs_cnt_q;
  logic [TAG_W-1:0]  head;
  logic [ID_W-1:0]   head_id;
  logic [LEN_W-1:0]  head_len;
  logic              fifo_full;
  logic              fifo_empty;

  // R path
  logic              rready;
  logic              r_hs;
  logic              r_last_hs;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic [1:0]        resp_acc_q, resp_acc_d;
  logic              id_err_q, len_err_q;
  logic              id_err_tot, len_err_tot;
  logic              done_err_d;

  // A request held in the slice counts against the budget, so a new command
  // is only taken once the slice is empty and a tag slot is free.
  assign cmd_ready = (state_q == AR_IDLE) & ~fifo_full &
                     (outs_cnt_q < CNT_W'(MAX_OUTS));
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign ar_hs     = arvalid & axi_mst.arready;

  // AR slice state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= AR_IDLE;
    else        state_q <= state_d;
  end

  // AR slice next state and arvalid
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    case (state_q)
      AR_IDLE: if (cmd_hs) state_d = AR_BUSY;
      AR_BUSY: begin
        arvalid = 1'b1;
        if (axi_mst.arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  // AR payload capture; held stable while arvalid waits for arready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else if (cmd_hs) begin
      araddr_q  <= cmd_addr;
      arlen_q   <= cmd_len;
      arsize_q  <= cmd_size;
      arburst_q <= cmd_burst;
    end
  end

  // ID counter: advances once per AR handshake and wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     id_cnt_q <= '0;
    else if (ar_hs) id_cnt_q <= id_cnt_q + ID_W'(1);
  end

  assign axi_mst.arid    = id_cnt_q;
  assign axi_mst.araddr  = araddr_q;
  assign axi_mst.arlen   = arlen_q;
  assign axi_mst.arsize  = arsize_q;
  assign axi_mst.arburst = arburst_q;
  assign axi_mst.arvalid = arvalid;

  axi_rd_tag_fifo #(
    .DEPTH (MAX_OUTS),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ar_hs),
    .push_data ({id_cnt_q, arlen_q}),
    .pop       (r_last_hs),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_id  = head[TAG_W-1:LEN_W];
  assign head_len = head[LEN_W-1:0];

  // Outstanding count: issue and completion in one cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs_cnt_q <= '0;
    end else begin
      case ({ar_hs, r_last_hs})
        2'b10:   outs_cnt_q <= outs_cnt_q + CNT_W'(1);
        2'b01:   outs_cnt_q <= outs_cnt_q - CNT_W'(1);
        default: outs_cnt_q <= outs_cnt_q;
      endcase
    end
  end

  assign outs_cnt = outs_cnt_q;

  // R acceptance only while some burst is expected
  assign rready         = rready_en & ~fifo_empty;
  assign axi_mst.rready = rready;
  assign r_hs           = axi_mst.rvalid & rready;
  assign r_last_hs      = r_hs & axi_mst.rlast;

  // Per-beat checks; the accumulator restarts on the first beat of a burst
  always_comb begin
    resp_acc_d  = (beat_cnt_q == '0) ? axi_mst.rresp
                                     : resp_max(axi_mst.rresp, resp_acc_q);
    id_err_tot  = id_err_q | (axi_mst.rid != head_id);
    len_err_tot = len_err_q |
                  (axi_mst.rlast ? (beat_cnt_q != head_len)
                                 : (beat_cnt_q == head_len));
    done_err_d  = resp_acc_d[1] | id_err_tot | len_err_tot;
  end

  // Beat counter, response accumulator and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      resp_acc_q <= '0;
      id_err_q   <= 1'b0;
      len_err_q  <= 1'b0;
    end else if (r_hs) begin
      resp_acc_q <= resp_acc_d;
      if (axi_mst.rlast) begin
        beat_cnt_q <= '0;
        id_err_q   <= 1'b0;
        len_err_q  <= 1'b0;
      end else begin
        if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + LEN_W'(1);
        id_err_q  <= id_err_tot;
        len_err_q <= len_err_tot;
      end
    end
  end

  // Registered beat stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_valid <= 1'b0;
      beat_data  <= '0;
      beat_idx   <= '0;
    end else begin
      beat_valid <= r_hs;
      if (r_hs) begin
        beat_data <= axi_mst.rdata;
        beat_idx  <= beat_cnt_q;
      end
    end
  end

  // Completion record, one cycle after the rlast handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid <= 1'b0;
      done_id    <= '0;
      done_resp  <= '0;
      done_beats <= '0;
      done_err   <= 1'b0;
    end else begin
      done_valid <= r_last_hs;
      if (r_last_hs) begin
        done_id    <= head_id;
        done_resp  <= resp_acc_d;
        done_beats <= {1'b0, beat_cnt_q} + (LEN_W+1)'(1);
        done_err   <= done_err_d;
      end
    end
  end

  // Saturating error counter, updated alongside the completion record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (r_last_hs && done_err_d && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_rd_mst_ctrl.sv
// Directed, scoreboarded bench for axi_rd_mst_ctrl. The bench plays the AXI
// slave; expected AR requests, beats and completions are queued when
// stimulus is driven and compared as the DUT produces them.
module tb_axi_rd_mst_ctrl;
  import axi_rd_mst_ctrl_pkg::*;

  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 8;
  localparam int MAX_OUTS = 4, ERRCNT_W = 16, CNT_W = 3;

  typedef struct { logic [ID_W-1:0] id; logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len;
                   logic [2:0] size; logic [1:0] burst; } ar_exp_t;
  typedef struct { logic [DATA_W-1:0] data; logic [LEN_W-1:0] idx; } beat_exp_t;
  typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; logic [LEN_W:0] beats;
                   logic err; } done_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [2:0]        cmd_size = '0;
  logic [1:0]        cmd_burst = '0;
  logic              rready_en = 1'b1;
  logic              beat_valid;
  logic [DATA_W-1:0] beat_data;
  logic [LEN_W-1:0]  beat_idx;
  logic              done_valid;
  logic [ID_W-1:0]   done_id;
  logic [1:0]        done_resp;
  logic [LEN_W:0]    done_beats;
  logic              done_err;
  logic [CNT_W-1:0]  outs_cnt;
  logic [ERRCNT_W-1:0] err_cnt;

  axi_rd_mst_ctrl_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) axi ();

  axi_rd_mst_ctrl #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .MAX_OUTS(MAX_OUTS), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .rready_en(rready_en), .axi_mst(axi.master),
    .beat_valid(beat_valid), .beat_data(beat_data), .beat_idx(beat_idx),
    .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp),
    .done_beats(done_beats), .done_err(done_err),
    .outs_cnt(outs_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ar_exp_t   ar_q[$];
  ar_exp_t   tag_q[$];
  beat_exp_t beat_q[$];
  done_exp_t done_q[$];

  logic [ID_W-1:0] mdl_next_id = '0;
  int   mdl_errcnt = 0;
  int   mdl_cnt = 0;
  logic [1:0] mdl_acc = '0;
  logic mdl_id_err = 1'b0;
  logic mdl_len_err = 1'b0;
  logic hs_r = 1'b0;
  logic cmd_taken = 1'b0;
  logic [ID_W-1:0] last_arid = '0;
  int   ar_cnt = 0;

  task automatic check(input logic [63:0] observed, input logic [63:0] expected, input string tag);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: sample handshakes and outputs on the falling edge, return just after the rising edge
  task automatic tick();
    ar_exp_t e;
    beat_exp_t b;
    done_exp_t d;
    @(negedge clk);
    hs_r = axi.rvalid & axi.rready;
    if (cmd_valid && cmd_ready && rst_n) begin
      ar_q.push_back('{id: mdl_next_id, addr: cmd_addr, len: cmd_len, size: cmd_size, burst: cmd_burst});
      mdl_next_id = mdl_next_id + 1'b1;
      cmd_taken = 1'b1;
    end
    if (axi.arvalid && axi.arready) begin
      check(64'(ar_q.size() != 0), 1, "ar_unexpected");
      if (ar_q.size() != 0) begin
        e = ar_q.pop_front();
        check(axi.arid, e.id, "arid");
        check(axi.araddr, e.addr, "araddr");
        check(axi.arlen, e.len, "arlen");
        check({axi.arsize, axi.arburst}, {e.size, e.burst}, "arsize_burst");
        tag_q.push_back(e);
        last_arid = axi.arid;
        ar_cnt++;
      end
    end
    if (beat_valid) begin
      check(64'(beat_q.size() != 0), 1, "beat_unexpected");
      if (beat_q.size() != 0) begin
        b = beat_q.pop_front();
        check(beat_data, b.data, "beat_data");
        check(beat_idx, b.idx, "beat_idx");
      end
    end
    if (done_valid) begin
      check(64'(done_q.size() != 0), 1, "done_unexpected");
      if (done_q.size() != 0) begin
        d = done_q.pop_front();
        check(done_id, d.id, "done_id");
        check(done_resp, d.resp, "done_resp");
        check(done_beats, d.beats, "done_beats");
        check(done_err, d.err, "done_err");
      end
    end
    @(posedge clk);
    #1;
    if (cmd_taken) cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                          input logic [1:0] burst);
    cmd_addr = addr; cmd_len = len; cmd_size = AXI_SIZE_4B; cmd_burst = burst;
    cmd_taken = 1'b0;
    cmd_valid = 1'b1;
    for (int n = 0; n < 100 && !cmd_taken; n++) tick();
    check(cmd_taken, 1, "cmd_timeout");
    cmd_valid = 1'b0;
  endtask

  // Drive one R beat for the oldest issued burst and update the reference model
  task automatic send_beat(input logic [DATA_W-1:0] data, input logic [1:0] resp,
                           input logic last, input logic bad_id);
    ar_exp_t head;
    logic got;
    logic err;
    for (int n = 0; n < 50 && tag_q.size() == 0; n++) tick();
    check(64'(tag_q.size() != 0), 1, "tag_wait");
    if (tag_q.size() == 0) return;
    head = tag_q[0];
    axi.rid = bad_id ? (head.id ^ 4'h1) : head.id;
    axi.rdata = data; axi.rresp = resp; axi.rlast = last; axi.rvalid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      got = hs_r;
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    check(got, 1, "r_hs_timeout");
    if (!got) return;
    beat_q.push_back('{data: data, idx: LEN_W'(mdl_cnt)});
    mdl_acc = (mdl_cnt == 0) ? resp : ((resp > mdl_acc) ? resp : mdl_acc);
    if (bad_id) mdl_id_err = 1'b1;
    if (last ? (mdl_cnt != int'(head.len)) : (mdl_cnt == int'(head.len))) mdl_len_err = 1'b1;
    if (last) begin
      err = mdl_acc[1] | mdl_id_err | mdl_len_err;
      done_q.push_back('{id: head.id, resp: mdl_acc, beats: (LEN_W+1)'(mdl_cnt + 1), err: err});
      if (err) mdl_errcnt++;
      void'(tag_q.pop_front());
      mdl_cnt = 0; mdl_id_err = 1'b0; mdl_len_err = 1'b0;
    end else begin
      mdl_cnt++;
    end
  endtask

  // Let pending beats and completions drain, then confirm nothing is left over
  task automatic drain(input string tag);
    for (int n = 0; n < 50 && (beat_q.size() != 0 || done_q.size() != 0); n++) tick();
    for (int n = 0; n < 3; n++) tick();
    check(64'(beat_q.size() + done_q.size()), 0, {tag, "_drain"});
    check(err_cnt, ERRCNT_W'(mdl_errcnt), {tag, "_err_cnt"});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({beat_valid, done_valid, done_err, axi.arvalid, axi.rready}, 0, {tag, "_flags"});
    check({outs_cnt, err_cnt, done_beats, done_resp, done_id}, 0, {tag, "_counts"});
    check({beat_data, beat_idx}, 0, {tag, "_beat"});
  endtask

  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    axi.rid = '0; axi.rdata = '0; axi.rresp = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: single INCR burst; AR held stable under arready=0
    send_cmd(32'h10, 8'd3, AXI_BURST_INCR);
    tick(); tick();
    check({axi.arvalid, axi.araddr}, {1'b1, 32'h10}, "ar_hold");
    axi.arready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'hA0 + 32'(i), AXI_RESP_OKAY, i == 3, 1'b0);
    drain("t1");
    check(outs_cnt, 0, "t1_outs");

    // 2: four outstanding bursts block the fifth command until an rlast
    for (int i = 0; i < 4; i++) send_cmd(32'h200 + 32'(i * 16), 8'd0, AXI_BURST_INCR);
    cmd_addr = 32'h300; cmd_len = 8'd0; cmd_taken = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check(cmd_taken, 0, "cmd5_blocked");
    end
    check(outs_cnt, 4, "t2_outs_full");
    send_beat(32'hB0, AXI_RESP_OKAY, 1'b1, 1'b0);
    for (int n = 0; n < 20 && !cmd_taken; n++) tick();
    check(cmd_taken, 1, "cmd5_taken");
    for (int i = 1; i < 5; i++) send_beat(32'hB0 + 32'(i), AXI_RESP_OKAY, 1'b1, 1'b0);
    drain("t2");

    // 3: worst response is kept, then restarts on the next burst
    send_cmd(32'h400, 8'd3, AXI_BURST_INCR);
    send_beat(32'hC0, AXI_RESP_OKAY, 1'b0, 1'b0);
    send_beat(32'hC1, AXI_RESP_EXOKAY, 1'b0, 1'b0);
    send_beat(32'hC2, AXI_RESP_SLVERR, 1'b0, 1'b0);
    send_beat(32'hC3, AXI_RESP_OKAY, 1'b1, 1'b0);
    drain("t3a");
    send_cmd(32'h500, 8'd1, AXI_BURST_WRAP);
    send_beat(32'hC4, AXI_RESP_OKAY, 1'b0, 1'b0);
    send_beat(32'hC5, AXI_RESP_OKAY, 1'b1, 1'b0);
    drain("t3b");

    // 4: early rlast, then late rlast
    send_cmd(32'h600, 8'd3, AXI_BURST_INCR);
    for (int i = 0; i < 3; i++) send_beat(32'hD0 + 32'(i), AXI_RESP_OKAY, i == 2, 1'b0);
    send_cmd(32'h700, 8'd3, AXI_BURST_FIXED);
    for (int i = 0; i < 6; i++) send_beat(32'hE0 + 32'(i), AXI_RESP_OKAY, i == 5, 1'b0);
    drain("t4");

    // 5: RID mismatch, then R throttled by rready_en
    send_cmd(32'h800, 8'd1, AXI_BURST_INCR);
    send_beat(32'hF0, AXI_RESP_OKAY, 1'b0, 1'b1);
    send_beat(32'hF1, AXI_RESP_OKAY, 1'b1, 1'b0);
    drain("t5a");
    send_cmd(32'h900, 8'd1, AXI_BURST_INCR);
    for (int n = 0; n < 20 && tag_q.size() == 0; n++) tick();
    rready_en = 1'b0;
    axi.rid = mdl_next_id - 1'b1; axi.rdata = 32'h5A5A; axi.rresp = '0; axi.rvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check({axi.rready, hs_r}, 0, "throttle");
    end
    rready_en = 1'b1;
    send_beat(32'h5A5A, AXI_RESP_OKAY, 1'b0, 1'b0);
    send_beat(32'h5A5B, AXI_RESP_OKAY, 1'b1, 1'b0);
    drain("t5b");

    // 6: reset with bursts in flight, then 17 ARs to wrap the ID
    send_cmd(32'hA00, 8'd3, AXI_BURST_INCR);
    send_cmd(32'hB00, 8'd3, AXI_BURST_INCR);
    send_beat(32'h77, AXI_RESP_SLVERR, 1'b0, 1'b0);
    rst_n = 1'b0;
    ar_q.delete(); tag_q.delete(); beat_q.delete(); done_q.delete();
    mdl_next_id = '0; mdl_errcnt = 0; mdl_cnt = 0; mdl_id_err = 1'b0; mdl_len_err = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check({outs_cnt, err_cnt}, 0, "post_rst_counts");
    ar_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      send_cmd(32'h1000 + 32'(i * 4), 8'd0, AXI_BURST_INCR);
      send_beat(32'h100 + 32'(i), AXI_RESP_OKAY, 1'b1, 1'b0);
    end
    drain("t6");
    check(ar_cnt, 17, "t6_ar_count");
    check(last_arid, 0, "id_wrap");
    check(64'(ar_q.size() + tag_q.size()), 0, "final_queues");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "timeout");
  end

endmodule
